// File: rtl/operand2_encoder.sv
// Finds the 12-bit {rot, imm8} data-processing immediate for a 32-bit constant,
// trying the plain value first and then its complement, one rotation per cycle.
module operand2_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic        inv,
  output logic [3:0]  rot,
  output logic [7:0]  imm8,
  output logic [11:0] operand2
);

  typedef enum logic [1:0] {IDLE, SEARCH, SEARCH_INV, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  r_q, r_d;
  logic [31:0] val_q, val_d;
  logic        found_q, found_d;
  logic        inv_q, inv_d;
  logic [3:0]  rot_q, rot_d;
  logic [7:0]  imm8_q, imm8_d;

  logic [31:0] test_word;
  logic [5:0]  shift_amt;
  logic [31:0] rot_word;
  logic        hit;

  assign test_word = (state_q == SEARCH_INV) ? ~val_q : val_q;
  assign shift_amt = {1'b0, r_q[3:0], 1'b0};
  // A right shift by 32 yields zero, so shift_amt == 0 degenerates to the plain word.
  assign rot_word  = (test_word << shift_amt) | (test_word >> (6'd32 - shift_amt));
  assign hit       = (rot_word[31:8] == 24'd0);

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    val_d   = val_q;
    found_d = found_q;
    inv_d   = inv_q;
    rot_d   = rot_q;
    imm8_d  = imm8_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          val_d   = value;
          r_d     = 5'd0;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (hit) begin
          found_d = 1'b1;
          inv_d   = 1'b0;
          rot_d   = r_q[3:0];
          imm8_d  = rot_word[7:0];
          state_d = DONE;
        end else if (r_q[3:0] == 4'hF) begin
          r_d     = 5'd0;
          state_d = SEARCH_INV;
        end else begin
          r_d = r_q + 5'd1;
        end
      end
      SEARCH_INV: begin
        // r == 16 is a closing slot after the last complement miss, so a
        // not-found result lands one cycle after the final rotation test.
        if (r_q[4]) begin
          found_d = 1'b0;
          inv_d   = 1'b0;
          rot_d   = 4'd0;
          imm8_d  = 8'd0;
          state_d = DONE;
        end else if (hit) begin
          found_d = 1'b1;
          inv_d   = 1'b1;
          rot_d   = r_q[3:0];
          imm8_d  = rot_word[7:0];
          state_d = DONE;
        end else begin
          r_d = r_q + 5'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      r_q     <= 5'd0;
      val_q   <= 32'd0;
      found_q <= 1'b0;
      inv_q   <= 1'b0;
      rot_q   <= 4'd0;
      imm8_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      val_q   <= val_d;
      found_q <= found_d;
      inv_q   <= inv_d;
      rot_q   <= rot_d;
      imm8_q  <= imm8_d;
    end
  end

  assign busy     = (state_q == SEARCH) || (state_q == SEARCH_INV);
  assign done     = (state_q == DONE);
  assign found    = found_q;
  assign inv      = inv_q;
  assign rot      = rot_q;
  assign imm8     = imm8_q;
  assign operand2 = {rot_q, imm8_q};

endmodule
